// File: rtl/univ_shift_reg_pkg.sv
// usr_pkg: shared control encodings and types for the universal shift register.
//   usr_ctrl_t : 2-bit operation select
//   CTRL_HOLD  : keep current contents
//   CTRL_SHL   : shift left, serial-in from d[0]
//   CTRL_SHR   : shift right, serial-in from d[N-1]
//   CTRL_LOAD  : parallel load from d
package usr_pkg;

    typedef logic [1:0] usr_ctrl_t;

    localparam usr_ctrl_t CTRL_HOLD = 2'b00;
    localparam usr_ctrl_t CTRL_SHL  = 2'b01;
    localparam usr_ctrl_t CTRL_SHR  = 2'b10;
    localparam usr_ctrl_t CTRL_LOAD = 2'b11;

endpackage

// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: data/control bundle of the universal shift register.
//   ctrl_amisha : operation select (usr_pkg encodings), driven by master
//   d_amisha    : parallel data / serial-in source, driven by master
//   q_amisha    : registered contents, driven by slave (the register)
// Optional: USR_CLK_ENABLE_EN is the build macro for the clock-enable feature;
// the enable itself is a plain port on univ_shift_reg, not part of this bundle.
interface univ_shift_reg_if #(
    parameter int unsigned N = 8
);
    import usr_pkg::*;

    usr_ctrl_t      ctrl_amisha;
    logic [N-1:0]   d_amisha;
    logic [N-1:0]   q_amisha;

    modport master (
        output ctrl_amisha,
        output d_amisha,
        input  q_amisha
    );

    modport slave (
        input  ctrl_amisha,
        input  d_amisha,
        output q_amisha
    );

endinterface

// File: rtl/univ_shift_reg_next_mux.sv
// usr_next_mux: combinational next-state selector for the shift register.
//   ctrl_i   : operation select
//   q_i      : current register contents
//   d_i      : parallel data; d_i[0] is the SHL serial-in, d_i[N-1] the SHR serial-in
//   q_next_o : value the register takes on the next enabled edge
module usr_next_mux
    import usr_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  usr_ctrl_t    ctrl_i,
    input  logic [N-1:0] q_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_next_o
);

    always_comb begin
        q_next_o = q_i;
        case (ctrl_i)
            CTRL_SHL:  q_next_o = {q_i[N-2:0], d_i[0]};
            CTRL_SHR:  q_next_o = {d_i[N-1], q_i[N-1:1]};
            CTRL_LOAD: q_next_o = d_i;
            // CTRL_HOLD and any non-binary ctrl keep the contents
            default:   q_next_o = q_i;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: N-bit universal shift register (hold / shl / shr / load).
//   clk_amisha   : clock, all updates on rising edge
//   reset_amisha : synchronous active-high reset, clears contents, beats ctrl
//   en_amisha    : clock enable (present only with USR_CLK_ENABLE_EN defined)
//   bus          : univ_shift_reg_if slave (ctrl_amisha, d_amisha in; q_amisha out)
// q_amisha comes straight from the register; no input-to-output path.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic clk_amisha,
    input  logic reset_amisha,
`ifdef USR_CLK_ENABLE_EN
    input  logic en_amisha,
`endif
    univ_shift_reg_if.slave bus
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    usr_next_mux #(.N(N)) u_next_mux (
        .ctrl_i   (bus.ctrl_amisha),
        .q_i      (q_q),
        .d_i      (bus.d_amisha),
        .q_next_o (q_d)
    );

    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            q_q <= '0;
`ifdef USR_CLK_ENABLE_EN
        end else if (en_amisha) begin
`else
        end else begin
`endif
            q_q <= q_d;
        end
    end

    assign bus.q_amisha = q_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed vectors with hand-computed expectations for
// univ_shift_reg (N=8). Stimulus pushes each expected q into a scoreboard
// queue; an independent monitor pops and compares after every rising edge.
module tb_univ_shift_reg;
    import usr_pkg::*;

    localparam int unsigned N = 8;

    typedef struct {
        logic [N-1:0] exp;
        int           id;
    } sb_entry_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
`ifdef USR_CLK_ENABLE_EN
    logic en  = 1'b1;
`endif

    univ_shift_reg_if #(.N(N)) bus ();

    univ_shift_reg #(.N(N)) dut (
        .clk_amisha   (clk),
        .reset_amisha (rst),
`ifdef USR_CLK_ENABLE_EN
        .en_amisha    (en),
`endif
        .bus          (bus)
    );

    always #5 clk = ~clk;

    sb_entry_t sb[$];
    int tests  = 0;
    int failed = 0;
    int step_n = 0;
    bit done   = 1'b0;

    // One clocked operation: drive on the falling edge, record expected q.
    task automatic step(input logic r, input usr_ctrl_t c,
                        input logic [N-1:0] d, input logic [N-1:0] exp);
        sb_entry_t e;
        @(negedge clk);
        rst             = r;
        bus.ctrl_amisha = c;
        bus.d_amisha    = d;
        e.exp = exp;
        e.id  = step_n;
        step_n++;
        sb.push_back(e);
    endtask

    // Monitor: compare q one time unit after each rising edge.
    initial begin
        sb_entry_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                tests++;
                if (bus.q_amisha !== e.exp) begin
                    failed++;
                    $display("FAIL step%0d q: got %h expected %h", e.id, bus.q_amisha, e.exp);
                end
            end
        end
    end

    initial begin
        bus.ctrl_amisha = CTRL_HOLD;
        bus.d_amisha    = '0;

        // Reset held two edges with load requested; then release on hold
        step(1'b1, CTRL_LOAD, 8'hFF, 8'h00);
        step(1'b1, CTRL_LOAD, 8'hFF, 8'h00);
        step(1'b0, CTRL_HOLD, 8'hFF, 8'h00);

        // Load then shift left
        step(1'b0, CTRL_LOAD, 8'hD3, 8'hD3);
        step(1'b0, CTRL_SHL,  8'hD3, 8'hA7);
        step(1'b0, CTRL_SHL,  8'hD3, 8'h4F);

        // Reload then shift right
        step(1'b0, CTRL_LOAD, 8'hD3, 8'hD3);
        step(1'b0, CTRL_SHR,  8'hD3, 8'hE9);
        step(1'b0, CTRL_SHR,  8'hD3, 8'hF4);

        // Hold while d toggles
        step(1'b0, CTRL_LOAD, 8'h5A, 8'h5A);
        step(1'b0, CTRL_HOLD, 8'h00, 8'h5A);
        step(1'b0, CTRL_HOLD, 8'hFF, 8'h5A);
        step(1'b0, CTRL_HOLD, 8'h00, 8'h5A);

        // Serial-in isolation: only d[0] enters on SHL, only d[7] on SHR
        step(1'b0, CTRL_LOAD, 8'h00, 8'h00);
        step(1'b0, CTRL_SHL,  8'h01, 8'h01);
        step(1'b0, CTRL_SHL,  8'h01, 8'h03);
        step(1'b0, CTRL_SHL,  8'h01, 8'h07);
        step(1'b0, CTRL_SHL,  8'h01, 8'h0F);
        step(1'b0, CTRL_SHL,  8'h01, 8'h1F);
        step(1'b0, CTRL_SHL,  8'h01, 8'h3F);
        step(1'b0, CTRL_SHL,  8'h01, 8'h7F);
        step(1'b0, CTRL_SHL,  8'h01, 8'hFF);
        step(1'b0, CTRL_SHR,  8'h7F, 8'h7F);
        step(1'b0, CTRL_SHR,  8'h7F, 8'h3F);
        step(1'b0, CTRL_SHR,  8'h7F, 8'h1F);
        step(1'b0, CTRL_SHR,  8'h7F, 8'h0F);
        step(1'b0, CTRL_SHR,  8'h7F, 8'h07);
        step(1'b0, CTRL_SHR,  8'h7F, 8'h03);
        step(1'b0, CTRL_SHR,  8'h7F, 8'h01);
        step(1'b0, CTRL_SHR,  8'h7F, 8'h00);

        // Reset mid-stream beats a pending shift; then resume immediately
        step(1'b0, CTRL_LOAD, 8'hD3, 8'hD3);
        step(1'b0, CTRL_SHL,  8'hD3, 8'hA7);
        step(1'b1, CTRL_SHL,  8'hD3, 8'h00);
        step(1'b0, CTRL_SHL,  8'h01, 8'h01);
        step(1'b0, CTRL_SHR,  8'h80, 8'h80);

`ifdef USR_CLK_ENABLE_EN
        // Enable low freezes the register; reset still clears it
        step(1'b0, CTRL_LOAD, 8'h81, 8'h81);
        @(negedge clk); en = 1'b0;
        step(1'b0, CTRL_LOAD, 8'h3C, 8'h81);
        step(1'b0, CTRL_SHL,  8'h3C, 8'h81);
        step(1'b1, CTRL_LOAD, 8'h3C, 8'h00);
        step(1'b0, CTRL_LOAD, 8'h3C, 8'h00);
        @(negedge clk); en = 1'b1;
        step(1'b0, CTRL_LOAD, 8'h3C, 8'h3C);
`endif

        // Let the last expectation drain, then make sure nothing was left over
        @(negedge clk);
        bus.ctrl_amisha = CTRL_HOLD;
        repeat (2) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
